reservation_station: RTL and testbench

- Arithmetic/branch reservation station. Sits directly downstream of the dispatch stage and consumes its registered non-memory instruction packets (dispatch_rs_rdy path).
- Holds instructions until both source operands are available, captured either at dispatch or from the two CDB broadcasts.
- Each cycle issues at most one ready entry to the ALU.
- Flushed on branch misprediction.

---
 rtl/reservation_station_if.sv | 47 ++++
 rtl/reservation_station.sv | 204 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and ALU-issue bundle for the arithmetic/branch reservation station.
interface reservation_station_if #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32
);
   logic              dispatch_rs_rdy;
   logic [DATA_W-1:0] in_inst;
   logic [DATA_W-1:0] in_npc;
   logic [DATA_W-1:0] in_imme;
   logic [TAG_W-1:0]  in_rob_tag;
   logic              in_rs1_ready;
   logic [DATA_W-1:0] in_vj;
   logic [TAG_W-1:0]  in_qj;
   logic              in_rs2_ready;
   logic [DATA_W-1:0] in_vk;
   logic [TAG_W-1:0]  in_qk;
   logic              alu_cdb_valid;
   logic [TAG_W-1:0]  alu_cdb_tag;
   logic [DATA_W-1:0] alu_cdb_value;
   logic              lsb_cdb_valid;
   logic [TAG_W-1:0]  lsb_cdb_tag;
   logic [DATA_W-1:0] lsb_cdb_value;
   logic              rs_full;
   logic              alu_valid;
   logic [DATA_W-1:0] alu_inst;
   logic [DATA_W-1:0] alu_npc;
   logic [DATA_W-1:0] alu_imme;
   logic [DATA_W-1:0] alu_vj;
   logic [DATA_W-1:0] alu_vk;
   logic [TAG_W-1:0]  alu_rob_tag;

   modport slave (
      input  dispatch_rs_rdy, in_inst, in_npc, in_imme, in_rob_tag,
      input  in_rs1_ready, in_vj, in_qj, in_rs2_ready, in_vk, in_qk,
      input  alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
      input  lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value,
      output rs_full, alu_valid, alu_inst, alu_npc, alu_imme, alu_vj, alu_vk, alu_rob_tag
   );

   modport master (
      output dispatch_rs_rdy, in_inst, in_npc, in_imme, in_rob_tag,
      output in_rs1_ready, in_vj, in_qj, in_rs2_ready, in_vk, in_qk,
      output alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
      output lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value,
      input  rs_full, alu_valid, alu_inst, alu_npc, alu_imme, alu_vj, alu_vk, alu_rob_tag
   );
endinterface

// File: rtl/reservation_station.sv
// Arithmetic/branch reservation station: holds dispatched packets until both operands
// are known (at dispatch or via the ALU/LSB CDBs) and issues the lowest ready entry.
module reservation_station #(
   parameter int RS_SIZE  = 16,
   parameter int RS_IDX_W = 4,
   parameter int TAG_W    = 4,
   parameter int DATA_W   = 32
) (
   input logic clk_in,
   input logic rst_in,
   input logic rdy_in,
   input logic clear_in,
   reservation_station_if.slave rs_if
);
   localparam int CW = RS_IDX_W + 1;
   localparam logic [CW-1:0] SIZE_C = CW'(RS_SIZE);

   typedef struct packed {
      logic              busy;
      logic [DATA_W-1:0] inst;
      logic [DATA_W-1:0] npc;
      logic [DATA_W-1:0] imme;
      logic [TAG_W-1:0]  rob_tag;
      logic              rj;
      logic [DATA_W-1:0] vj;
      logic [TAG_W-1:0]  qj;
      logic              rk;
      logic [DATA_W-1:0] vk;
      logic [TAG_W-1:0]  qk;
   } entry_t;

   entry_t            ent_q [RS_SIZE];
   entry_t            ent_d [RS_SIZE];
   logic [CW-1:0]     count_q, count_d;
   logic              rs_full_q, rs_full_d;
   logic              alu_valid_q, alu_valid_d;
   logic [DATA_W-1:0] alu_inst_q, alu_inst_d;
   logic [DATA_W-1:0] alu_npc_q, alu_npc_d;
   logic [DATA_W-1:0] alu_imme_q, alu_imme_d;
   logic [DATA_W-1:0] alu_vj_q, alu_vj_d;
   logic [DATA_W-1:0] alu_vk_q, alu_vk_d;
   logic [TAG_W-1:0]  alu_rob_tag_q, alu_rob_tag_d;

   logic                free_found_s;
   logic [RS_IDX_W-1:0] free_idx_s;
   logic                issue_found_s;
   logic [RS_IDX_W-1:0] issue_idx_s;
   logic [DATA_W:0]     disp_j_s;
   logic [DATA_W:0]     disp_k_s;
   logic                alloc_s;

   // Resolve one operand: already ready, or captured from a matching CDB (ALU first).
   function automatic logic [DATA_W:0] capture_fn(
      input logic              rdy,
      input logic [DATA_W-1:0] v,
      input logic [TAG_W-1:0]  q,
      input logic              a_vld,
      input logic [TAG_W-1:0]  a_tag,
      input logic [DATA_W-1:0] a_val,
      input logic              l_vld,
      input logic [TAG_W-1:0]  l_tag,
      input logic [DATA_W-1:0] l_val
   );
      logic [DATA_W:0] r;
      if (rdy) begin
         r = {1'b1, v};
      end else if (a_vld && (a_tag == q)) begin
         r = {1'b1, a_val};
      end else if (l_vld && (l_tag == q)) begin
         r = {1'b1, l_val};
      end else begin
         r = {1'b0, v};
      end
      return r;
   endfunction

   // Lowest free entry and lowest ready entry, both from pre-edge state.
   always_comb begin
      free_found_s  = 1'b0;
      free_idx_s    = '0;
      issue_found_s = 1'b0;
      issue_idx_s   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         free_found_s  = free_found_s | ~ent_q[i].busy;
         free_idx_s    = ent_q[i].busy ? free_idx_s : RS_IDX_W'(i);
         issue_found_s = issue_found_s | (ent_q[i].busy & ent_q[i].rj & ent_q[i].rk);
         issue_idx_s   = (ent_q[i].busy & ent_q[i].rj & ent_q[i].rk) ? RS_IDX_W'(i) : issue_idx_s;
      end
   end

   // Operand values for the incoming packet, including same-cycle CDB bypass.
   always_comb begin
      disp_j_s = capture_fn(rs_if.in_rs1_ready, rs_if.in_vj, rs_if.in_qj,
                            rs_if.alu_cdb_valid, rs_if.alu_cdb_tag, rs_if.alu_cdb_value,
                            rs_if.lsb_cdb_valid, rs_if.lsb_cdb_tag, rs_if.lsb_cdb_value);
      disp_k_s = capture_fn(rs_if.in_rs2_ready, rs_if.in_vk, rs_if.in_qk,
                            rs_if.alu_cdb_valid, rs_if.alu_cdb_tag, rs_if.alu_cdb_value,
                            rs_if.lsb_cdb_valid, rs_if.lsb_cdb_tag, rs_if.lsb_cdb_value);
   end

   // Next state: freeze, flush, or wakeup + issue + allocate.
   always_comb begin
      ent_d         = ent_q;
      count_d       = count_q;
      rs_full_d     = rs_full_q;
      alu_valid_d   = 1'b0;
      alu_inst_d    = alu_inst_q;
      alu_npc_d     = alu_npc_q;
      alu_imme_d    = alu_imme_q;
      alu_vj_d      = alu_vj_q;
      alu_vk_d      = alu_vk_q;
      alu_rob_tag_d = alu_rob_tag_q;
      alloc_s       = rs_if.dispatch_rs_rdy & free_found_s;
      if (!rdy_in) begin
         alu_valid_d = 1'b0;
      end else if (clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i].busy = 1'b0;
         end
         count_d   = '0;
         rs_full_d = 1'b0;
      end else begin
         // Wakeup is harmless on idle entries: allocation overwrites them anyway.
         for (int i = 0; i < RS_SIZE; i++) begin
            {ent_d[i].rj, ent_d[i].vj} = capture_fn(ent_q[i].rj, ent_q[i].vj, ent_q[i].qj,
                rs_if.alu_cdb_valid, rs_if.alu_cdb_tag, rs_if.alu_cdb_value,
                rs_if.lsb_cdb_valid, rs_if.lsb_cdb_tag, rs_if.lsb_cdb_value);
            {ent_d[i].rk, ent_d[i].vk} = capture_fn(ent_q[i].rk, ent_q[i].vk, ent_q[i].qk,
                rs_if.alu_cdb_valid, rs_if.alu_cdb_tag, rs_if.alu_cdb_value,
                rs_if.lsb_cdb_valid, rs_if.lsb_cdb_tag, rs_if.lsb_cdb_value);
         end
         if (issue_found_s) begin
            ent_d[issue_idx_s].busy = 1'b0;
            alu_valid_d   = 1'b1;
            alu_inst_d    = ent_q[issue_idx_s].inst;
            alu_npc_d     = ent_q[issue_idx_s].npc;
            alu_imme_d    = ent_q[issue_idx_s].imme;
            alu_vj_d      = ent_q[issue_idx_s].vj;
            alu_vk_d      = ent_q[issue_idx_s].vk;
            alu_rob_tag_d = ent_q[issue_idx_s].rob_tag;
         end else begin
            alu_valid_d = 1'b0;
         end
         if (alloc_s) begin
            ent_d[free_idx_s].busy    = 1'b1;
            ent_d[free_idx_s].inst    = rs_if.in_inst;
            ent_d[free_idx_s].npc     = rs_if.in_npc;
            ent_d[free_idx_s].imme    = rs_if.in_imme;
            ent_d[free_idx_s].rob_tag = rs_if.in_rob_tag;
            ent_d[free_idx_s].rj      = disp_j_s[DATA_W];
            ent_d[free_idx_s].vj      = disp_j_s[DATA_W-1:0];
            ent_d[free_idx_s].qj      = rs_if.in_qj;
            ent_d[free_idx_s].rk      = disp_k_s[DATA_W];
            ent_d[free_idx_s].vk      = disp_k_s[DATA_W-1:0];
            ent_d[free_idx_s].qk      = rs_if.in_qk;
         end else begin
            ent_d[free_idx_s] = ent_d[free_idx_s];
         end
         count_d   = count_q + CW'(alloc_s) - CW'(issue_found_s);
         // One spare slot is kept for the packet already in flight in dispatch.
         rs_full_d = ((SIZE_C - count_d) <= CW'(1));
      end
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= '0;
         end
         count_q       <= '0;
         rs_full_q     <= 1'b0;
         alu_valid_q   <= 1'b0;
         alu_inst_q    <= '0;
         alu_npc_q     <= '0;
         alu_imme_q    <= '0;
         alu_vj_q      <= '0;
         alu_vk_q      <= '0;
         alu_rob_tag_q <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_q[i] <= ent_d[i];
         end
         count_q       <= count_d;
         rs_full_q     <= rs_full_d;
         alu_valid_q   <= alu_valid_d;
         alu_inst_q    <= alu_inst_d;
         alu_npc_q     <= alu_npc_d;
         alu_imme_q    <= alu_imme_d;
         alu_vj_q      <= alu_vj_d;
         alu_vk_q      <= alu_vk_d;
         alu_rob_tag_q <= alu_rob_tag_d;
      end
   end

   assign rs_if.rs_full     = rs_full_q;
   assign rs_if.alu_valid   = alu_valid_q;
   assign rs_if.alu_inst    = alu_inst_q;
   assign rs_if.alu_npc     = alu_npc_q;
   assign rs_if.alu_imme    = alu_imme_q;
   assign rs_if.alu_vj      = alu_vj_q;
   assign rs_if.alu_vk      = alu_vk_q;
   assign rs_if.alu_rob_tag = alu_rob_tag_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wakeup, bypass, fill, flush, pause, reset.
module tb_reservation_station;
   logic clk_in   = 1'b0;
   logic rst_in   = 1'b0;
   logic rdy_in   = 1'b1;
   logic clear_in = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   reservation_station_if #(.TAG_W(4), .DATA_W(32)) rs_if ();

   reservation_station #(.RS_SIZE(16), .RS_IDX_W(4), .TAG_W(4), .DATA_W(32)) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .clear_in (clear_in),
      .rs_if    (rs_if)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle;
      rs_if.dispatch_rs_rdy = 1'b0;
      rs_if.in_inst         = 32'd0;
      rs_if.in_npc          = 32'd0;
      rs_if.in_imme         = 32'd0;
      rs_if.in_rob_tag      = 4'd0;
      rs_if.in_rs1_ready    = 1'b0;
      rs_if.in_vj           = 32'd0;
      rs_if.in_qj           = 4'd0;
      rs_if.in_rs2_ready    = 1'b0;
      rs_if.in_vk           = 32'd0;
      rs_if.in_qk           = 4'd0;
      rs_if.alu_cdb_valid   = 1'b0;
      rs_if.alu_cdb_tag     = 4'd0;
      rs_if.alu_cdb_value   = 32'd0;
      rs_if.lsb_cdb_valid   = 1'b0;
      rs_if.lsb_cdb_tag     = 4'd0;
      rs_if.lsb_cdb_value   = 32'd0;
   endtask

   task automatic disp(input logic [31:0] inst, input logic [3:0] tag,
                       input logic r1, input logic [31:0] vj, input logic [3:0] qj,
                       input logic r2, input logic [31:0] vk, input logic [3:0] qk);
      rs_if.dispatch_rs_rdy = 1'b1;
      rs_if.in_inst         = inst;
      rs_if.in_npc          = 32'h1000 + 32'(tag);
      rs_if.in_imme         = 32'h10 + 32'(tag);
      rs_if.in_rob_tag      = tag;
      rs_if.in_rs1_ready    = r1;
      rs_if.in_vj           = vj;
      rs_if.in_qj           = qj;
      rs_if.in_rs2_ready    = r2;
      rs_if.in_vk           = vk;
      rs_if.in_qk           = qk;
   endtask

   task automatic no_issue(input string nm);
      chk(nm, 32'(rs_if.alu_valid), 32'd0);
   endtask

   task automatic issued(input string nm, input logic [3:0] tag,
                         input logic [31:0] vj, input logic [31:0] vk);
      chk({nm, "_valid"}, 32'(rs_if.alu_valid), 32'd1);
      chk({nm, "_tag"}, 32'(rs_if.alu_rob_tag), 32'(tag));
      chk({nm, "_vj"}, rs_if.alu_vj, vj);
      chk({nm, "_vk"}, rs_if.alu_vk, vk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      #7;
      chk("reset_valid", 32'(rs_if.alu_valid), 32'd0);
      chk("reset_full", 32'(rs_if.rs_full), 32'd0);
      chk("reset_vj", rs_if.alu_vj, 32'd0);
      chk("reset_inst", rs_if.alu_inst, 32'd0);
      #5;
      rst_in = 1'b1;

      // Ready dispatch issues one edge later, for exactly one cycle
      disp(32'h00500093, 4'd3, 1'b1, 32'd7, 4'd0, 1'b1, 32'd0, 4'd0);
      step();
      idle();
      no_issue("t1_disp_edge");
      step();
      issued("t1_issue", 4'd3, 32'd7, 32'd0);
      chk("t1_inst", rs_if.alu_inst, 32'h00500093);
      chk("t1_npc", rs_if.alu_npc, 32'h1003);
      chk("t1_imme", rs_if.alu_imme, 32'h13);
      step();
      no_issue("t1_one_cycle");

      // Wakeup from ALU CDB two cycles after dispatch
      disp(32'h11, 4'd4, 1'b0, 32'd0, 4'd5, 1'b1, 32'd9, 4'd0);
      step();
      idle();
      no_issue("t2_disp_edge");
      step();
      no_issue("t2_wait");
      rs_if.alu_cdb_valid = 1'b1;
      rs_if.alu_cdb_tag   = 4'd5;
      rs_if.alu_cdb_value = 32'h1234;
      step();
      idle();
      no_issue("t2_wake_edge");
      step();
      issued("t2_issue", 4'd4, 32'h1234, 32'd9);
      step();
      no_issue("t2_after");

      // Same-cycle LSB bypass at dispatch
      disp(32'h22, 4'd6, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd2);
      rs_if.lsb_cdb_valid = 1'b1;
      rs_if.lsb_cdb_tag   = 4'd2;
      rs_if.lsb_cdb_value = 32'hFF;
      step();
      idle();
      no_issue("t3_disp_edge");
      step();
      issued("t3_issue", 4'd6, 32'd1, 32'hFF);

      // Fill 15 entries, entry i waits on tag i
      for (int i = 0; i < 15; i++) begin
         disp(32'h100 + 32'(i), 4'(i), 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0);
         step();
         no_issue("t4_fill_noissue");
         if (i == 13) chk("t4_full_at_14", 32'(rs_if.rs_full), 32'd0);
      end
      idle();
      chk("t4_full_at_15", 32'(rs_if.rs_full), 32'd1);
      rs_if.alu_cdb_valid = 1'b1;
      rs_if.alu_cdb_tag   = 4'd5;
      rs_if.alu_cdb_value = 32'h55;
      step();
      idle();
      no_issue("t4_wake_edge");
      chk("t4_full_wake", 32'(rs_if.rs_full), 32'd1);
      step();
      issued("t4_issue5", 4'd5, 32'h55, 32'd0);
      chk("t4_full_freed", 32'(rs_if.rs_full), 32'd0);
      // X must land in freed entry 5, Y in entry 15; X then issues first
      disp(32'h200, 4'hA, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, 4'd0);
      step();
      chk("t4_full_x", 32'(rs_if.rs_full), 32'd1);
      no_issue("t4_x_edge");
      disp(32'h201, 4'hB, 1'b0, 32'd0, 4'hF, 1'b1, 32'd0, 4'd0);
      step();
      idle();
      chk("t4_full_y", 32'(rs_if.rs_full), 32'd1);
      rs_if.alu_cdb_valid = 1'b1;
      rs_if.alu_cdb_tag   = 4'hF;
      rs_if.alu_cdb_value = 32'hF0;
      step();
      idle();
      no_issue("t4_wake_f");
      step();
      issued("t4_issue_x", 4'hA, 32'hF0, 32'd0);
      step();
      issued("t4_issue_y", 4'hB, 32'hF0, 32'd0);
      chk("t4_full_after_y", 32'(rs_if.rs_full), 32'd0);
      step();
      no_issue("t4_quiet");

      // Flush with concurrent ready dispatch
      clear_in = 1'b1;
      disp(32'h300, 4'hD, 1'b1, 32'h33, 4'd0, 1'b1, 32'd0, 4'd0);
      step();
      clear_in = 1'b0;
      idle();
      no_issue("t5_flush_edge");
      chk("t5_flush_full", 32'(rs_if.rs_full), 32'd0);
      step();
      no_issue("t5_disp_dropped");
      rs_if.alu_cdb_valid = 1'b1;
      rs_if.alu_cdb_tag   = 4'd0;
      rs_if.lsb_cdb_valid = 1'b1;
      rs_if.lsb_cdb_tag   = 4'd1;
      step();
      idle();
      step();
      no_issue("t5_empty");

      // Pause: ready entry held for 3 frozen cycles, dispatch during pause ignored
      disp(32'h400, 4'hC, 1'b1, 32'h77, 4'd0, 1'b1, 32'd3, 4'd0);
      step();
      rdy_in = 1'b0;
      disp(32'h401, 4'hE, 1'b1, 32'hEE, 4'd0, 1'b1, 32'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         no_issue("t6_paused");
      end
      rdy_in = 1'b1;
      idle();
      step();
      issued("t6_issue", 4'hC, 32'h77, 32'd3);
      step();
      no_issue("t6_ignored_disp");

      // Reset mid-operation with 3 waiting entries
      disp(32'h500, 4'd1, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
      step();
      disp(32'h501, 4'd2, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
      step();
      disp(32'h502, 4'd3, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
      step();
      disp(32'h503, 4'd7, 1'b1, 32'h99, 4'd0, 1'b1, 32'd0, 4'd0);
      step();
      idle();
      no_issue("t7_disp_edge");
      step();
      issued("t7_pre_reset", 4'd7, 32'h99, 32'd0);
      #2;
      rst_in = 1'b0;
      #1;
      no_issue("t7_reset_valid");
      chk("t7_reset_full", 32'(rs_if.rs_full), 32'd0);
      chk("t7_reset_vj", rs_if.alu_vj, 32'd0);
      #1;
      rst_in = 1'b1;
      disp(32'h600, 4'h8, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
      step();
      disp(32'h601, 4'h9, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0);
      step();
      idle();
      rs_if.alu_cdb_valid = 1'b1;
      rs_if.alu_cdb_tag   = 4'd1;
      rs_if.alu_cdb_value = 32'h11;
      rs_if.lsb_cdb_valid = 1'b1;
      rs_if.lsb_cdb_tag   = 4'd2;
      rs_if.lsb_cdb_value = 32'h22;
      step();
      idle();
      no_issue("t7_wake_edge");
      step();
      issued("t7_issue_entry0", 4'h8, 32'h11, 32'd0);
      step();
      issued("t7_issue_entry1", 4'h9, 32'h22, 32'd0);
      step();
      no_issue("t7_empty");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
